div_ref_model: RTL and testbench

- Sequential golden reference divider for the divider bench.
- Accepts one unsigned dividend/divisor pair per start pulse and computes quotient and remainder by restoring division, one bit per cycle.
- Presents results on qc/sc with a done pulse; the end-of-test checkers compare these against the DUT quotient (q) and remainder (s).
- Sits in the bench alongside the DUT, driven by the same stimulus as the DUT.

---
 rtl/div_pkg.sv | 24 ++
 rtl/div_restore_step.sv | 30 +++
 rtl/div_ref_model.sv | 147 ++++++++++++++
 tb/tb_div_ref_model.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the restoring reference divider.
// The divide-by-zero quotient value is also defined here.
package div_pkg;

    localparam int DIV_W = 9;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_RUN  = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

    // All-ones quotient reported for a zero divisor, right-aligned to w bits
    function automatic logic [63:0] div_zero_quotient(input int unsigned w);
        logic [63:0] ones_v;
        ones_v = {64{1'b1}};
        if (w >= 32'd64) begin
            return ones_v;
        end else begin
            return ones_v >> (32'd64 - w);
        end
    endfunction

endpackage

// File: rtl/div_restore_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract,
// and keep the difference only when it is non-negative.
module div_restore_step
    import div_pkg::*;
#(
    parameter int W = DIV_W
) (
    input  logic [W:0]   r,
    input  logic         q_msb,
    input  logic [W-1:0] d,
    output logic [W:0]   r_next,
    output logic         q_bit
);

    logic [W+1:0] shifted_s;
    logic [W+1:0] diff_s;

    // Trial subtraction; the extra top bit of diff_s acts as the borrow/sign
    always_comb begin
        shifted_s = {r, q_msb};
        diff_s    = shifted_s - {2'b00, d};
        q_bit     = ~diff_s[W+1];
        if (q_bit) begin
            r_next = diff_s[W:0];
        end else begin
            r_next = shifted_s[W:0];
        end
    end

endmodule

// File: rtl/div_ref_model.sv
// Sequential golden reference divider: unsigned restoring division, one quotient
// bit per clock, with abort, divide-by-zero shortcut and held results.
module div_ref_model
    import div_pkg::*;
#(
    parameter int W  = DIV_W,
    parameter int CW = $clog2(W + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         abort,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic         div_zero,
    output logic [W-1:0] qc,
    output logic [W-1:0] sc
);

    localparam logic [W-1:0]  QZERO    = W'(div_zero_quotient(W));
    localparam logic [CW-1:0] CNT_LOAD = CW'(W);
    localparam logic [CW-1:0] CNT_ONE  = CW'(32'd1);

    div_state_e     state_r, state_nxt_s;
    logic [CW-1:0]  cnt_r, cnt_nxt_s;
    logic [W-1:0]   q_r, q_nxt_s;
    logic [W-1:0]   d_r, d_nxt_s;
    logic [W:0]     r_r, r_nxt_s;
    logic [W-1:0]   qc_r, qc_nxt_s;
    logic [W-1:0]   sc_r, sc_nxt_s;
    logic           busy_r, busy_nxt_s;
    logic           done_r, done_nxt_s;
    logic           dz_r, dz_nxt_s;

    logic [W:0]     step_r_s;
    logic           step_q_bit_s;
    logic [W-1:0]   q_shift_s;

    div_restore_step #(.W(W)) u_step (
        .r      (r_r),
        .q_msb  (q_r[W-1]),
        .d      (d_r),
        .r_next (step_r_s),
        .q_bit  (step_q_bit_s)
    );

    assign q_shift_s = {q_r[W-2:0], step_q_bit_s};

    // Next-state and next-datapath decode; results only move on completion
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        q_nxt_s     = q_r;
        d_nxt_s     = d_r;
        r_nxt_s     = r_r;
        qc_nxt_s    = qc_r;
        sc_nxt_s    = sc_r;
        dz_nxt_s    = dz_r;
        done_nxt_s  = 1'b0;
        case (state_r)
            DIV_IDLE, DIV_DONE: begin
                if (start) begin
                    q_nxt_s   = dividend;
                    d_nxt_s   = divisor;
                    r_nxt_s   = {(W + 1){1'b0}};
                    cnt_nxt_s = CNT_LOAD;
                    dz_nxt_s  = 1'b0;
                    if (divisor == {W{1'b0}}) begin
                        state_nxt_s = DIV_DONE;
                        qc_nxt_s    = QZERO;
                        sc_nxt_s    = dividend;
                        dz_nxt_s    = 1'b1;
                        done_nxt_s  = 1'b1;
                    end else begin
                        state_nxt_s = DIV_RUN;
                    end
                end else begin
                    state_nxt_s = state_r;
                end
            end
            DIV_RUN: begin
                if (abort) begin
                    state_nxt_s = DIV_IDLE;
                end else begin
                    cnt_nxt_s = cnt_r - CNT_ONE;
                    q_nxt_s   = q_shift_s;
                    r_nxt_s   = step_r_s;
                    if (cnt_r == CNT_ONE) begin
                        state_nxt_s = DIV_DONE;
                        qc_nxt_s    = q_shift_s;
                        sc_nxt_s    = step_r_s[W-1:0];
                        done_nxt_s  = 1'b1;
                    end else begin
                        state_nxt_s = DIV_RUN;
                    end
                end
            end
            default: begin
                state_nxt_s = DIV_IDLE;
            end
        endcase
        busy_nxt_s = (state_nxt_s == DIV_RUN);
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= DIV_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Working registers and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r  <= {CW{1'b0}};
            q_r    <= {W{1'b0}};
            d_r    <= {W{1'b0}};
            r_r    <= {(W + 1){1'b0}};
            qc_r   <= {W{1'b0}};
            sc_r   <= {W{1'b0}};
            busy_r <= 1'b0;
            done_r <= 1'b0;
            dz_r   <= 1'b0;
        end else begin
            cnt_r  <= cnt_nxt_s;
            q_r    <= q_nxt_s;
            d_r    <= d_nxt_s;
            r_r    <= r_nxt_s;
            qc_r   <= qc_nxt_s;
            sc_r   <= sc_nxt_s;
            busy_r <= busy_nxt_s;
            done_r <= done_nxt_s;
            dz_r   <= dz_nxt_s;
        end
    end

    assign busy     = busy_r;
    assign done     = done_r;
    assign div_zero = dz_r;
    assign qc       = qc_r;
    assign sc       = sc_r;

endmodule

// File: tb/tb_div_ref_model.sv
// Self-checking bench for div_ref_model: cycle-level behavioural model using
// plain / and %, directed vectors with literal expectations, and a random sweep.
module tb_div_ref_model;

    localparam int W = 9;

    logic         clk, rst, start, abort;
    logic [W-1:0] dividend, divisor;
    logic         busy, done, div_zero;
    logic [W-1:0] qc, sc;

    int n_pass  = 0;
    int n_total = 0;
    bit chk_en  = 1'b0;

    int m_rem, m_pq, m_pr, m_qc, m_sc;
    bit m_dz, m_done, m_busy;

    int cyc, bc, seen, a, b;

    div_ref_model #(.W(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .abort    (abort),
        .dividend (dividend),
        .divisor  (divisor),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .qc       (qc),
        .sc       (sc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Behavioural model: a run lasts W cycles and yields dividend/divisor, dividend%divisor
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_rem = 0; m_qc = 0; m_sc = 0; m_dz = 0; m_done = 0; m_busy = 0;
        end else begin
            m_done = 0;
            if (m_rem > 0) begin
                if (abort) begin
                    m_rem = 0;
                end else begin
                    m_rem--;
                    if (m_rem == 0) begin
                        m_qc = m_pq; m_sc = m_pr; m_done = 1;
                    end
                end
            end else if (start) begin
                if (divisor == 0) begin
                    m_qc = (1 << W) - 1; m_sc = int'(dividend); m_dz = 1; m_done = 1;
                end else begin
                    m_dz = 0; m_rem = W;
                    m_pq = int'(dividend) / int'(divisor);
                    m_pr = int'(dividend) % int'(divisor);
                end
            end
            m_busy = (m_rem > 0);
        end
    end

    always @(posedge clk) begin
        #1;
        if (chk_en && !rst) begin
            chk("busy", busy, m_busy);
            chk("done", done, m_done);
            chk("div_zero", div_zero, m_dz);
            chk("qc", qc, m_qc);
            chk("sc", sc, m_sc);
        end
    end

    task automatic start_op(input int op_a, input int op_b);
        @(negedge clk);
        dividend = W'(op_a);
        divisor  = W'(op_b);
        start    = 1'b1;
        @(posedge clk);
        #2;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int max, output int cycles, output int busy_cycles);
        cycles = 1;
        busy_cycles = 0;
        while (done !== 1'b1 && cycles <= max) begin
            if (busy === 1'b1) busy_cycles++;
            @(posedge clk);
            #2;
            cycles++;
        end
        chk({name, "_done_seen"}, done, 1'b1);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; dividend = '0; divisor = '0;
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_dz", div_zero, 0);
        chk("rst_qc", qc, 0);
        chk("rst_sc", sc, 0);
        @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;

        start_op(500, 7);
        wait_done("t1", 20, cyc, bc);
        chk("t1_qc", qc, 71);
        chk("t1_sc", sc, 3);
        chk("t1_dz", div_zero, 0);
        chk("t1_busy_cycles", bc, 9);
        chk("t1_latency", cyc, 10);

        start_op(511, 1);
        wait_done("t2a", 20, cyc, bc);
        chk("t2a_qc", qc, 511);
        chk("t2a_sc", sc, 0);
        start_op(5, 9);
        wait_done("t2b", 20, cyc, bc);
        chk("t2b_qc", qc, 0);
        chk("t2b_sc", sc, 5);
        chk("t2b_latency", cyc, 10);

        start_op(300, 0);
        wait_done("t3a", 5, cyc, bc);
        chk("t3a_latency", cyc, 1);
        chk("t3a_qc", qc, 511);
        chk("t3a_sc", sc, 300);
        chk("t3a_dz", div_zero, 1);
        start_op(100, 10);
        chk("t3b_dz_cleared", div_zero, 0);
        wait_done("t3b", 20, cyc, bc);
        chk("t3b_qc", qc, 10);
        chk("t3b_sc", sc, 0);

        start_op(400, 3);
        repeat (4) @(negedge clk);
        dividend = 9; divisor = 2; start = 1'b1;
        @(posedge clk);
        #2;
        start = 1'b0;
        chk("t4_still_busy", busy, 1);
        wait_done("t4", 20, cyc, bc);
        chk("t4_qc", qc, 133);
        chk("t4_sc", sc, 1);

        start_op(255, 16);
        repeat (3) @(negedge clk);
        abort = 1'b1;
        @(posedge clk);
        #2;
        abort = 1'b0;
        chk("t5_abort_busy", busy, 0);
        seen = 0;
        repeat (15) begin
            @(posedge clk);
            #2;
            if (done === 1'b1) seen++;
        end
        chk("t5_no_done", seen, 0);
        chk("t5_qc_kept", qc, 133);
        chk("t5_sc_kept", sc, 1);
        start_op(255, 16);
        wait_done("t5r", 20, cyc, bc);
        chk("t5r_qc", qc, 15);
        chk("t5r_sc", sc, 15);

        start_op(255, 16);
        repeat (4) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_done", done, 0);
        chk("t6_rst_dz", div_zero, 0);
        chk("t6_rst_qc", qc, 0);
        chk("t6_rst_sc", sc, 0);
        @(negedge clk);
        rst = 1'b0;
        start_op(255, 16);
        wait_done("t6r", 20, cyc, bc);
        chk("t6r_qc", qc, 15);
        chk("t6r_sc", sc, 15);

        for (int i = 0; i < 2000; i++) begin
            a = $urandom_range(0, 511);
            b = $urandom_range(1, 511);
            start_op(a, b);
            wait_done("rnd", 15, cyc, bc);
            chk("rnd_identity", 32'(qc) * 32'(b) + 32'(sc), a);
            chk("rnd_rem_lt_div", 32'(sc) < 32'(b), 1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
